// File: rtl/weight_fetch_control.sv
// Weight fetch sequencer: streams one command's rows from the weight buffer and
// tracks the three-cycle read latency so each row arrives tagged with its array row.
module weight_fetch_control #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  localparam int RW          = $clog2(MATRIX_WIDTH + 1),
  localparam int IW          = $clog2(MATRIX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [RW-1:0]         cmd_rows,
  output logic                  buf_en,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic                  row_valid,
  output logic [IW-1:0]         row_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [RW-1:0]           rows_q, rows_d;
  logic                    zdone_q, zdone_d;
  logic [2:0]              pv_q, pv_d;
  logic [2:0][IW-1:0]      pidx_q, pidx_d;
  logic                    issue_s;
  logic [RW-1:0]           rows_clamped_s;
  logic                    last_issue_s;
  logic                    last_row_s;

  assign rows_clamped_s = (cmd_rows > RW'(MATRIX_WIDTH)) ? RW'(MATRIX_WIDTH) : cmd_rows;
  assign last_issue_s   = (RW'(cnt_q) == (rows_q - RW'(1)));
  // Stage 2 holds the row currently on the buffer output; the final row marks completion.
  assign last_row_s     = pv_q[2] && (RW'(pidx_q[2]) == (rows_q - RW'(1)));

  assign row_valid = enable & pv_q[2];
  assign row_index = pidx_q[2];
  assign done      = enable & (zdone_q | ((state_q == DRAIN) & last_row_s));

  // State, counter, command latch and latency pipe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      zdone_q <= 1'b0;
      pv_q    <= '0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      zdone_q <= zdone_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
    end
  end

  // Next-state decode, read issue and pipe advance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    rows_d    = rows_q;
    zdone_d   = zdone_q;
    pv_d      = pv_q;
    pidx_d    = pidx_q;
    issue_s   = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    buf_en    = 1'b0;
    buf_addr  = '0;

    case (state_q)
      IDLE: begin
        // A zero-row command's done pulse occupies the next cycle; hold off new commands.
        cmd_ready = ~zdone_q;
        if (enable) begin
          zdone_d = 1'b0;
          if (cmd_valid && !zdone_q) begin
            base_d = cmd_addr;
            rows_d = rows_clamped_s;
            cnt_d  = '0;
            if (rows_clamped_s == RW'(0)) begin
              zdone_d = 1'b1;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          zdone_d = zdone_q;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        buf_en   = enable;
        buf_addr = base_q + ADDR_WIDTH'(cnt_q);
        if (enable) begin
          issue_s = 1'b1;
          if (last_issue_s) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (enable && last_row_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enable) begin
      pv_d   = {pv_q[1:0], issue_s};
      pidx_d = {pidx_q[1:0], (issue_s ? cnt_q : IW'(0))};
    end else begin
      pv_d   = pv_q;
      pidx_d = pidx_q;
    end
  end

endmodule

// File: tb/tb_weight_fetch_control.sv
// Directed bench for weight_fetch_control: full-matrix, zero-row, wrap, clamp,
// stall, enable gating, reset abort and back-to-back commands.
module tb_weight_fetch_control;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [3:0]  cmd_rows;
  logic        buf_en;
  logic [23:0] buf_addr;
  logic        row_valid;
  logic [3:0]  row_index;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  weight_fetch_control #(.MATRIX_WIDTH(14), .ADDR_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
    .buf_en(buf_en), .buf_addr(buf_addr),
    .row_valid(row_valid), .row_index(row_index),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status vector order: {buf_en, row_valid, done, busy, cmd_ready}
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_addr = 24'h0; cmd_rows = 4'd0;
    step(); step();
    #3;
    n_tests++;
    if ({buf_en, row_valid, done, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected %b", {buf_en, row_valid, done, busy, cmd_ready}, 5'b00001);
    end
    n_tests++;
    if (buf_addr !== 24'h0 || row_index !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_addr_idx: got %h/%0d expected 000000/0", buf_addr, row_index);
    end
    rst = 1'b0; enable = 1'b1;
  endtask

  // Unstalled command of exp_rows>0 rows: accept in cycle 0, issues 1..N, rows 4..N+3.
  task automatic run_plain(input string name, input logic [23:0] addr,
                           input logic [3:0] rows_in, input int exp_rows);
    logic [23:0] exp_addr;
    logic [3:0]  exp_idx;
    logic [4:0]  exp_st;
    step();
    enable = 1'b1; cmd_valid = 1'b1; cmd_addr = addr; cmd_rows = rows_in;
    #3;
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: got ready=%b busy=%b expected ready=1 busy=0", name, cmd_ready, busy);
    end
    for (int k = 1; k <= exp_rows + 3; k++) begin
      step();
      cmd_valid = 1'b0;
      #3;
      exp_st = {(k <= exp_rows), (k >= 4), (k == exp_rows + 3), 1'b1, 1'b0};
      n_tests++;
      if ({buf_en, row_valid, done, busy, cmd_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL %s_status c%0d: got %b expected %b", name, k,
                 {buf_en, row_valid, done, busy, cmd_ready}, exp_st);
      end
      if (k <= exp_rows) begin
        exp_addr = addr + 24'(k - 1);
        n_tests++;
        if (buf_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s_addr c%0d: got %h expected %h", name, k, buf_addr, exp_addr);
        end
      end
      if (k >= 4) begin
        exp_idx = 4'(k - 4);
        n_tests++;
        if (row_index !== exp_idx) begin
          n_fail++;
          $display("FAIL %s_index c%0d: got %0d expected %0d", name, k, row_index, exp_idx);
        end
      end
    end
  endtask

  task automatic test_full_matrix();
    run_plain("full", 24'h000010, 4'd14, 14);
  endtask

  task automatic test_clamp();
    run_plain("clamp", 24'h000400, 4'd15, 14);
  endtask

  task automatic test_wrap();
    run_plain("wrap", 24'hFFFFFE, 4'd4, 4);
  endtask

  task automatic test_back_to_back();
    run_plain("b2b_a", 24'h000050, 4'd3, 3);
    run_plain("b2b_b", 24'h000060, 4'd1, 1);
  endtask

  task automatic test_zero_rows();
    step();
    enable = 1'b1; cmd_valid = 1'b1; cmd_addr = 24'h000123; cmd_rows = 4'd0;
    #3;
    n_tests++;
    if (cmd_ready !== 1'b1 || buf_en !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_accept: got ready=%b en=%b expected ready=1 en=0", cmd_ready, buf_en);
    end
    step();
    cmd_valid = 1'b0;
    #3;
    n_tests++;
    if ({buf_en, row_valid, done, busy} !== 4'b0010) begin
      n_fail++;
      $display("FAIL zero_done: got %b expected 0010", {buf_en, row_valid, done, busy});
    end
    for (int k = 2; k <= 4; k++) begin
      step();
      #3;
      n_tests++;
      if ({buf_en, row_valid, done, busy, cmd_ready} !== 5'b00001) begin
        n_fail++;
        $display("FAIL zero_after c%0d: got %b expected 00001", k, {buf_en, row_valid, done, busy, cmd_ready});
      end
    end
  endtask

  task automatic test_enable_gate();
    step();
    enable = 1'b0; cmd_valid = 1'b1; cmd_addr = 24'h000777; cmd_rows = 4'd2;
    step();
    step();
    cmd_valid = 1'b0; enable = 1'b1;
    #3;
    n_tests++;
    if ({buf_en, busy, cmd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL enable_gate: got %b expected 001", {buf_en, busy, cmd_ready});
    end
  endtask

  // Enable dropped in cycles 3 and 4: issues in 1,2,5,6,7; rows in 6..10; done at 10.
  task automatic test_stall();
    logic [4:0]  exp_st;
    logic [23:0] exp_addr;
    logic        en_k;
    step();
    enable = 1'b1; cmd_valid = 1'b1; cmd_addr = 24'h000100; cmd_rows = 4'd5;
    for (int k = 1; k <= 11; k++) begin
      step();
      cmd_valid = 1'b0;
      en_k = !(k == 3 || k == 4);
      enable = en_k;
      #3;
      exp_st = {(k == 1 || k == 2 || (k >= 5 && k <= 7)), (k >= 6 && k <= 10),
                (k == 10), (k <= 10), (k == 11)};
      n_tests++;
      if ({buf_en, row_valid, done, busy, cmd_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL stall_status c%0d: got %b expected %b", k,
                 {buf_en, row_valid, done, busy, cmd_ready}, exp_st);
      end
      if (exp_st[4]) begin
        exp_addr = 24'h000100 + ((k <= 2) ? 24'(k - 1) : 24'(k - 3));
        n_tests++;
        if (buf_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL stall_addr c%0d: got %h expected %h", k, buf_addr, exp_addr);
        end
      end
      if (exp_st[3]) begin
        n_tests++;
        if (row_index !== 4'(k - 6)) begin
          n_fail++;
          $display("FAIL stall_index c%0d: got %0d expected %0d", k, row_index, k - 6);
        end
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    step();
    enable = 1'b1; cmd_valid = 1'b1; cmd_addr = 24'h000200; cmd_rows = 4'd14;
    for (int k = 1; k <= 3; k++) begin
      step();
      cmd_valid = 1'b0;
      #3;
      n_tests++;
      if (buf_en !== 1'b1 || buf_addr !== 24'h000200 + 24'(k - 1)) begin
        n_fail++;
        $display("FAIL abort_issue c%0d: got en=%b addr=%h expected en=1 addr=%h", k, buf_en,
                 buf_addr, 24'h000200 + 24'(k - 1));
      end
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #3;
    n_tests++;
    if ({buf_en, row_valid, done, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL abort_ready: got %b expected 00001", {buf_en, row_valid, done, busy, cmd_ready});
    end
    for (int k = 6; k <= 10; k++) begin
      step();
      #3;
      n_tests++;
      if ({row_valid, done, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_quiet c%0d: got %b expected 000", k, {row_valid, done, busy});
      end
    end
    run_plain("after_abort", 24'h000030, 4'd2, 2);
  endtask

  initial begin
    test_reset();
    test_full_matrix();
    test_zero_rows();
    test_wrap();
    test_clamp();
    test_stall();
    test_enable_gate();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fetch_control.md
WEIGHT_FETCH_CONTROL -- requirements
Module: weight_fetch_control

Interface
REQ-001 The block SHALL have parameter MATRIX_WIDTH, default 14, setting the systolic array row count and the maximum rows per command.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 24, setting the weight buffer address width.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port enable  input  1  global advance; low freezes all state, in step with the weight buffer output registers.
REQ-006 The block SHALL have port cmd_valid  input  1  fetch command offered.
REQ-007 The block SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-008 The block SHALL have port cmd_addr  input  ADDR_WIDTH  first weight row address.
REQ-009 The block SHALL have port cmd_rows  input  $clog2(MATRIX_WIDTH+1)  rows to fetch, 0..MATRIX_WIDTH.
REQ-010 The block SHALL have port buf_en  output  1  weight buffer port read enable.
REQ-011 The block SHALL have port buf_addr  output  ADDR_WIDTH  weight buffer port address.
REQ-012 The block SHALL have port row_valid  output  1  weight buffer read data is valid this cycle.
REQ-013 The block SHALL have port row_index  output  $clog2(MATRIX_WIDTH)  array row targeted by the current read data.
REQ-014 The block SHALL have port busy  output  1  command in progress.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at command completion.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN; transitions occur only on cycles with enable=1.
REQ-017 IDLE: cmd_ready=1, busy=0; command accepted when cmd_valid=1 and enable=1; cmd_addr and cmd_rows latched.
REQ-018 On accept with cmd_rows=0: no read is issued, done pulses next cycle, state stays IDLE.
REQ-019 On accept with cmd_rows>0: next state is ISSUE with issue counter=0.
REQ-020 cmd_rows > MATRIX_WIDTH SHALL be clamped to MATRIX_WIDTH.
REQ-021 ISSUE: buf_en=enable, buf_addr=base+counter modulo 2^ADDR_WIDTH (wrap, no error); counter increments per enabled cycle; after issuing row cmd_rows-1, next state is DRAIN.
REQ-022 Read latency SHALL be 3 enabled cycles: a row issued in enabled cycle N has row_valid=1 in enabled cycle N+3 (RAM read plus two output register stages).
REQ-023 Latency tracking SHALL use a 3-stage valid/index shift pipe that advances only when enable=1.
REQ-024 row_valid and done SHALL be asserted only when enable=1; pipe contents hold while enable=0.
REQ-025 row_index SHALL equal the counter value used at issue, so rows arrive in order 0..cmd_rows-1.
REQ-026 DRAIN: buf_en=0; done pulses in the same cycle as the last row_valid; next state IDLE.
REQ-027 busy=1 in ISSUE and DRAIN; cmd_ready=0 outside IDLE; cmd_valid outside IDLE is ignored.
REQ-028 A new command is accepted no earlier than the cycle after done.

Reset
REQ-029 rst SHALL force IDLE, counter=0, pipe cleared; buf_en=0, buf_addr=0, row_valid=0, row_index=0, busy=0, done=0, cmd_ready=1 in the following cycle.
REQ-030 rst mid-command SHALL abort with no done pulse and no further row_valid; rst has priority over enable.

Verification
REQ-031 enable=1, cmd_addr=0x10, cmd_rows=14 -> buf_addr 0x10..0x1D on 14 consecutive cycles; row_valid for row_index 0..13 starting 3 cycles after the first issue; done with row 13; busy for 17 cycles.
REQ-032 cmd_rows=0 -> no buf_en; done one cycle after accept; busy stays 0.
REQ-033 cmd_addr=2^ADDR_WIDTH-2, cmd_rows=4 -> buf_addr sequence max-1, max, 0, 1; rows 0..3 delivered in order.
REQ-034 cmd_rows=5, enable low for 2 cycles after the second issue -> buf_en, row_valid, done low while stalled; all 5 rows still delivered in order; done 2 cycles later than unstalled.
REQ-035 rst asserted after the third issue of a 14-row command -> no further row_valid, no done; cmd_ready=1 next cycle; a new 2-row command then completes normally.
